// File: rtl/fma_32_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency FMA_32 pipeline.
// Latency: grant in T, fma_issue in T+1, response pulse in T+1+LAT; one issue per cycle.
// Backpressure: req_k_ready is a combinational grant; responses have no backpressure.
// Optional macro FMA_ARB_FIXED_PRIO_EN: requester 0 always wins a conflict (no RR pointer).
module fma_32_arbiter #(
  parameter int LAT = 3  // FMA pipeline depth, legal range 1..8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [95:0] req0_abc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [95:0] req1_abc,
  output logic        fma_issue,
  output logic [31:0] fma_a,
  output logic [31:0] fma_b,
  output logic [31:0] fma_c,
  input  logic [31:0] fma_result,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_data,
  output logic        busy
);

  logic           gnt0;
  logic           gnt1;
  logic           issue_own;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_own;

`ifdef FMA_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins any conflict.
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`else
  logic ptr;  // preferred requester when both are valid

  // Round-robin: preferred requester wins a conflict, a lone requester always wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0 = ~ptr;
      gnt1 = ptr;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  // Pointer moves to the requester that was not granted; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end
`endif

  // Ready is held low during reset so nothing is accepted before the first live edge.
  assign req0_ready = rst_n & gnt0;
  assign req1_ready = rst_n & gnt1;

  // Register the winning operands; operands hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fma_issue <= 1'b0;
      issue_own <= 1'b0;
      fma_a     <= '0;
      fma_b     <= '0;
      fma_c     <= '0;
    end else begin
      fma_issue <= gnt0 | gnt1;
      issue_own <= gnt1;
      if (gnt0) begin
        fma_a <= req0_abc[95:64];
        fma_b <= req0_abc[63:32];
        fma_c <= req0_abc[31:0];
      end else if (gnt1) begin
        fma_a <= req1_abc[95:64];
        fma_b <= req1_abc[63:32];
        fma_c <= req1_abc[31:0];
      end
    end
  end

  // Tag pipeline mirrors the FMA pipeline so the last stage lines up with fma_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld[0] <= fma_issue;
      tag_own[0] <= issue_own;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign resp0_valid = tag_vld[LAT-1] & ~tag_own[LAT-1];
  assign resp1_valid = tag_vld[LAT-1] &  tag_own[LAT-1];
  assign resp_data   = fma_result;
  assign busy        = fma_issue | (|tag_vld);

endmodule

// File: tb/tb_fma_32_arbiter.sv
// Directed bench for fma_32_arbiter with a stub LAT-deep FMA pipeline.
module tb_fma_32_arbiter;
  localparam int LAT = 3;
`ifdef FMA_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [95:0] req0_abc = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [95:0] req1_abc = '0;
  logic        fma_issue;
  logic [31:0] fma_a, fma_b, fma_c;
  logic [31:0] fma_result;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_data;
  logic        busy;

  int total = 0;
  int bad = 0;

  fma_32_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_abc(req0_abc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_abc(req1_abc),
    .fma_issue(fma_issue), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_result(fma_result),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub FMA: exact answer for the 2*3+1 vector, otherwise a^b^c as a traceable tag.
  function automatic logic [31:0] fake_fma(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (a == 32'h40000000 && b == 32'h40400000 && c == 32'h3F800000) return 32'h40E00000;
    return a ^ b ^ c;
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fake_fma(fma_a, fma_b, fma_c);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fma_result = pipe[LAT-1];

  task automatic do_reset;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk); #1;
    total++; if (fma_issue !== 1'b0) begin bad++; $display("FAIL rst_issue: got %b want 0", fma_issue); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if ({resp0_valid, resp1_valid} !== 2'b00) begin bad++; $display("FAIL rst_resp: got %b want 00", {resp0_valid, resp1_valid}); end
    total++; if ({fma_a, fma_b, fma_c} !== 96'h0) begin bad++; $display("FAIL rst_ops: got %h want 0", {fma_a, fma_b, fma_c}); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1;
    req0_abc = {32'h40000000, 32'h40400000, 32'h3F800000};
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    total++; if (fma_issue !== 1'b1) begin bad++; $display("FAIL single_issue: got %b want 1", fma_issue); end
    total++; if ({fma_a, fma_b, fma_c} !== {32'h40000000, 32'h40400000, 32'h3F800000}) begin
      bad++; $display("FAIL single_ops: got %h want 40000000404000003f800000", {fma_a, fma_b, fma_c}); end
    for (int k = 2; k <= LAT + 1; k++) begin
      @(negedge clk); #1;
      total++; if ({resp0_valid, resp1_valid} !== {(k == LAT + 1), 1'b0}) begin
        bad++; $display("FAIL single_resp c%0d: got %b want %b", k, {resp0_valid, resp1_valid}, {(k == LAT + 1), 1'b0}); end
      if (k == LAT + 1) begin
        total++; if (resp_data !== 32'h40E00000) begin bad++; $display("FAIL single_data: got %h want 40e00000", resp_data); end
      end
    end
  endtask

  task automatic test_round_robin;
    int n0, n1, j, ek;
    logic eo, eg1;
    logic [31:0] exp_d;
    n0 = 0; n1 = 0;
    do_reset();
    for (int i = 0; i <= 6 + LAT + 1; i++) begin
      @(negedge clk);
      if (i < 6) begin
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_abc = {32'hA0000000 + 32'(n0), 32'h1, 32'h0};
        req1_abc = {32'hB0000000 + 32'(n1), 32'h1, 32'h0};
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      #1;
      if (i < 6) begin
        eg1 = FIXED ? 1'b0 : i[0];
        total++; if ({req0_ready, req1_ready} !== {~eg1, eg1}) begin
          bad++; $display("FAIL rr_grant c%0d: got %b want %b", i, {req0_ready, req1_ready}, {~eg1, eg1}); end
      end
      if (i >= LAT + 1 && i < LAT + 7) begin
        j = i - LAT - 1;
        eo = FIXED ? 1'b0 : j[0];
        ek = FIXED ? j : j / 2;
        exp_d = ((eo ? 32'hB0000000 : 32'hA0000000) + 32'(ek)) ^ 32'h1;
        total++; if ({resp0_valid, resp1_valid} !== {~eo, eo}) begin
          bad++; $display("FAIL rr_resp c%0d: got %b want %b", i, {resp0_valid, resp1_valid}, {~eo, eo}); end
        total++; if (resp_data !== exp_d) begin bad++; $display("FAIL rr_data c%0d: got %h want %h", i, resp_data, exp_d); end
      end else begin
        total++; if ({resp0_valid, resp1_valid} !== 2'b00) begin
          bad++; $display("FAIL rr_idle c%0d: got %b want 00", i, {resp0_valid, resp1_valid}); end
      end
      if (req0_ready) n0++;
      if (req1_ready) n1++;
    end
  endtask

  task automatic test_req1_only;
    logic [1:0] exp_r;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i <= 4 + LAT + 1; i++) begin
      @(negedge clk);
      req0_valid = (i == 3);
      req1_valid = (i < 3);
      req0_abc = {32'hA0000000, 32'h1, 32'h0};
      req1_abc = {32'hB0000000 + 32'(i), 32'h1, 32'h0};
      #1;
      if (i < 3) begin
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL r1_grant c%0d: got %b want 01", i, {req0_ready, req1_ready}); end
      end else if (i == 3) begin
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL r1_then_r0: got %b want 10", {req0_ready, req1_ready}); end
      end
      exp_r = 2'b00;
      exp_d = 32'h0;
      if (i >= 4 && i <= 6) begin exp_r = 2'b01; exp_d = (32'hB0000000 + 32'(i - 4)) ^ 32'h1; end
      if (i == 7) begin exp_r = 2'b10; exp_d = 32'hA0000001; end
      total++; if ({resp0_valid, resp1_valid} !== exp_r) begin bad++; $display("FAIL r1_resp c%0d: got %b want %b", i, {resp0_valid, resp1_valid}, exp_r); end
      if (exp_r != 2'b00) begin
        total++; if (resp_data !== exp_d) begin bad++; $display("FAIL r1_data c%0d: got %h want %h", i, resp_data, exp_d); end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      req0_valid = (i <= 1) || (i == 8);
      req1_valid = (i == 8);
      req0_abc = {32'hC0000000 + 32'(i), 32'h1, 32'h0};
      if (i == 2) rst_n = 1'b0;
      if (i == 3) rst_n = 1'b1;
      #1;
      if (i <= 1) begin
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL mid_grant c%0d: got %b want 1", i, req0_ready); end
      end else if (i <= 7) begin
        total++; if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin
          bad++; $display("FAIL mid_flush c%0d: got %b want 000", i, {resp0_valid, resp1_valid, busy}); end
      end else begin
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL mid_ptr: got %b want 10", {req0_ready, req1_ready}); end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_idle_gap;
    do_reset();
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      req0_valid = (i == 0) || (i == 6);
      req0_abc = (i == 6) ? {32'h44444444, 32'h55555555, 32'h66666666} : {32'h11111111, 32'h22222222, 32'h33333333};
      #1;
      if (i == 1) begin
        total++; if ({fma_issue, busy} !== 2'b11) begin bad++; $display("FAIL gap_issue: got %b want 11", {fma_issue, busy}); end
      end
      if (i >= 2 && i <= 6) begin
        total++; if (busy !== (i <= LAT + 1)) begin bad++; $display("FAIL gap_busy c%0d: got %b want %b", i, busy, (i <= LAT + 1)); end
        total++; if ({fma_issue, fma_a, fma_b, fma_c} !== {1'b0, 32'h11111111, 32'h22222222, 32'h33333333}) begin
          bad++; $display("FAIL gap_hold c%0d: got %h want 0111111112222222233333333", i, {fma_issue, fma_a, fma_b, fma_c}); end
      end
      if (i == 7) begin
        total++; if ({fma_issue, fma_a, fma_b, fma_c} !== {1'b1, 32'h44444444, 32'h55555555, 32'h66666666}) begin
          bad++; $display("FAIL gap_second: got %h want 1444444445555555566666666", {fma_issue, fma_a, fma_b, fma_c}); end
      end
    end
    req0_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_req1_only();
    test_reset_mid();
    test_idle_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
